// File: rtl/encoder_4_2_sync_if.sv
// Bundles the request vector and the encoded result of the 4-to-2 encoder.
// The master drives A; the slave (the encoder) returns B/valid/err.
interface encoder_4_2_sync_if;
  logic [3:0] A;
  logic [1:0] B;
  logic       valid;
  logic       err;

  modport master (output A, input B, input valid, input err);
  modport slave  (input A, output B, output valid, output err);
endinterface

// File: rtl/encoder_4_2_sync.sv
// Registered 4-to-2 encoder with fixed-priority conflict resolution and
// flags for "no request" (valid=0) and "multiple requests" (err=1).
module encoder_4_2_sync #(
  parameter bit HIGH_PRIO = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  encoder_4_2_sync_if.slave  bus
);

  logic [1:0] b_d, b_q;
  logic       valid_d, valid_q;
  logic       err_d, err_q;
  logic [3:0] req;

  assign req = bus.A;

  // The last set bit visited by the scan wins, so scan direction sets the priority.
  always_comb begin
    b_d = 2'b00;
    if (HIGH_PRIO) begin
      for (int i = 0; i < 4; i++) begin
        if (req[i]) b_d = 2'(i);
      end
    end else begin
      for (int i = 3; i >= 0; i--) begin
        if (req[i]) b_d = 2'(i);
      end
    end
    valid_d = |req;
    // Clearing the lowest set bit leaves something only if two or more were set.
    err_d   = |(req & (req - 4'd1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_q     <= 2'b00;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      b_q     <= b_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign bus.B     = b_q;
  assign bus.valid = valid_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_encoder_4_2_sync.sv
// Directed bench for encoder_4_2_sync: one instance per priority setting,
// both fed the same A, outputs compared as {B, valid, err}.
module tb_encoder_4_2_sync;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_passed = 0;

  encoder_4_2_sync_if if_hi ();
  encoder_4_2_sync_if if_lo ();

  encoder_4_2_sync #(.HIGH_PRIO(1'b1)) dut_hi (.clk(clk), .rst(rst), .bus(if_hi.slave));
  encoder_4_2_sync #(.HIGH_PRIO(1'b0)) dut_lo (.clk(clk), .rst(rst), .bus(if_lo.slave));

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got {B,valid,err}=%b required %b", tag, got, exp);
    else
      n_passed++;
  endtask

  function automatic logic [3:0] out_hi();
    return {if_hi.B, if_hi.valid, if_hi.err};
  endfunction

  function automatic logic [3:0] out_lo();
    return {if_lo.B, if_lo.valid, if_lo.err};
  endfunction

  // Drive A, wait one edge, check both instances 1 ns after the edge.
  task automatic apply(input string tag, input logic [3:0] a,
                       input logic [3:0] exp_hi, input logic [3:0] exp_lo);
    if_hi.A = a;
    if_lo.A = a;
    @(posedge clk);
    #1;
    $display("txn %-10s rst=%b A=%b hi=%b lo=%b", tag, rst, a, out_hi(), out_lo());
    check_val({tag, "_hi"}, out_hi(), exp_hi);
    check_val({tag, "_lo"}, out_lo(), exp_lo);
  endtask

  logic [3:0] onehot_a [4];
  logic [3:0] onehot_e [4];
  logic [3:0] prev_e;

  initial begin
    onehot_a = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    onehot_e = '{4'b0010, 4'b0110, 4'b1010, 4'b1110};

    // Reset holds outputs low despite a request on A.
    rst = 1'b1;
    apply("rst0", 4'b1000, 4'b0000, 4'b0000);
    apply("rst1", 4'b1000, 4'b0000, 4'b0000);
    rst = 1'b0;

    // One-hot sweep; also confirm the old value holds until the next edge.
    prev_e = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if_hi.A = onehot_a[i];
      if_lo.A = onehot_a[i];
      #1;
      check_val("hold_hi", out_hi(), prev_e);
      check_val("hold_lo", out_lo(), prev_e);
      apply("onehot_a", onehot_a[i], onehot_e[i], onehot_e[i]);
      apply("onehot_b", onehot_a[i], onehot_e[i], onehot_e[i]);
      prev_e = onehot_e[i];
    end

    apply("idle", 4'b0000, 4'b0000, 4'b0000);

    // Conflicts: hi picks highest set index, lo picks lowest; err=1 in both.
    apply("c0110", 4'b0110, 4'b1011, 4'b0111);
    apply("c1111", 4'b1111, 4'b1111, 4'b0011);
    apply("c1010", 4'b1010, 4'b1111, 4'b0111);
    apply("c0011", 4'b0011, 4'b0111, 4'b0011);

    // Mid-run reset and release with no warm-up cycle.
    apply("pre_rst", 4'b0100, 4'b1010, 4'b1010);
    rst = 1'b1;
    apply("mid_rst", 4'b0100, 4'b0000, 4'b0000);
    rst = 1'b0;
    apply("release", 4'b0100, 4'b1010, 4'b1010);
    apply("idle2", 4'b0000, 4'b0000, 4'b0000);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
